// File: rtl/bob_resolve_ctrl.sv
// Branch-resolution sequencer: pairs each resolved branch with the BOB head, pops it,
// trains the predictor, and runs redirect plus timed flush/restore on a mispredict.
module bob_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic             res_taken_i,
  input  logic [63:0]      res_target_i,
  input  logic             ext_flush_i,
  input  logic             bob_valid_i,
  input  logic [63:0]      bob_pc_i,
  input  logic             bob_brdir_i,
  input  logic             bob_ch_we_i,
  input  logic             bob_ch_dir_i,
  input  logic [9:0]       bob_lochist_i,
  input  logic [11:0]      bob_bhr_i,
  input  logic [3:0]       bob_rasptr_i,
  output logic             bob_re_o,
  output logic             bob_flush_o,
  output logic             upd_valid_o,
  output logic [63:0]      upd_pc_o,
  output logic             upd_taken_o,
  output logic [9:0]       upd_lochist_o,
  output logic [11:0]      upd_bhr_o,
  output logic             ch_we_o,
  output logic             ch_dir_o,
  output logic             redirect_valid_o,
  output logic [63:0]      redirect_pc_o,
  output logic             rest_valid_o,
  output logic [11:0]      rest_bhr_o,
  output logic [9:0]       rest_lochist_o,
  output logic [3:0]       rest_rasptr_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StIdle, StCmp, StRecover} state_e;

  state_e state_q, state_d;

  logic        taken_q;
  logic [63:0] target_q;
  logic [63:0] pc_q;
  logic        brdir_q;
  logic        ch_we_q;
  logic        ch_dir_q;
  logic [9:0]  lochist_q;
  logic [11:0] bhr_q;
  logic [3:0]  rasptr_q;

  logic [3:0]  flush_cnt_q;
  logic        pulse_q;
  logic [63:0] redir_pc_q;
  logic [11:0] rest_bhr_q;
  logic [9:0]  rest_lochist_q;
  logic [3:0]  rest_rasptr_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  logic ready;
  logic accept;
  logic mispredict;
  logic enter_rec;

  assign ready      = (state_q == StIdle) & bob_valid_i & ~ext_flush_i;
  assign accept     = res_valid_i & ready;
  assign mispredict = brdir_q != taken_q;
  // An external flush in the compare cycle cancels recovery before it starts.
  assign enter_rec  = (state_q == StCmp) & mispredict & ~ext_flush_i;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCmp;
      end
      StCmp: begin
        if (enter_rec) state_d = StRecover;
        else           state_d = StIdle;
      end
      StRecover: begin
        if (ext_flush_i || flush_cnt_q <= 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Latched resolution, recovery data and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_q        <= 1'b0;
      target_q       <= '0;
      pc_q           <= '0;
      brdir_q        <= 1'b0;
      ch_we_q        <= 1'b0;
      ch_dir_q       <= 1'b0;
      lochist_q      <= '0;
      bhr_q          <= '0;
      rasptr_q       <= '0;
      flush_cnt_q    <= '0;
      pulse_q        <= 1'b0;
      redir_pc_q     <= '0;
      rest_bhr_q     <= '0;
      rest_lochist_q <= '0;
      rest_rasptr_q  <= '0;
      br_cnt_q       <= '0;
      mis_cnt_q      <= '0;
    end else begin
      if (accept) begin
        taken_q   <= res_taken_i;
        target_q  <= res_target_i;
        pc_q      <= bob_pc_i;
        brdir_q   <= bob_brdir_i;
        ch_we_q   <= bob_ch_we_i;
        ch_dir_q  <= bob_ch_dir_i;
        lochist_q <= bob_lochist_i;
        bhr_q     <= bob_bhr_i;
        rasptr_q  <= bob_rasptr_i;
      end

      pulse_q <= enter_rec;
      if (enter_rec) begin
        flush_cnt_q    <= FlushInit;
        redir_pc_q     <= taken_q ? target_q : pc_q + 64'd4;
        rest_bhr_q     <= {bhr_q[10:0], taken_q};
        rest_lochist_q <= {lochist_q[8:0], taken_q};
        rest_rasptr_q  <= rasptr_q;
      end else if (state_q == StRecover) begin
        flush_cnt_q <= ext_flush_i ? 4'd0 : flush_cnt_q - 4'd1;
      end

      // Saturating performance counters
      if (state_q == StCmp) begin
        if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (mispredict && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    res_ready_o      = ready;
    bob_re_o         = (state_q == StCmp);
    upd_valid_o      = (state_q == StCmp);
    ch_we_o          = (state_q == StCmp) & ch_we_q;
    ch_dir_o         = (state_q == StCmp) & ch_dir_q;
    upd_pc_o         = pc_q;
    upd_taken_o      = taken_q;
    upd_lochist_o    = lochist_q;
    upd_bhr_o        = bhr_q;
    bob_flush_o      = (state_q == StRecover) | ext_flush_i;
    redirect_valid_o = pulse_q;
    rest_valid_o     = pulse_q;
    redirect_pc_o    = redir_pc_q;
    rest_bhr_o       = rest_bhr_q;
    rest_lochist_o   = rest_lochist_q;
    rest_rasptr_o    = rest_rasptr_q;
    br_cnt_o         = br_cnt_q;
    mis_cnt_o        = mis_cnt_q;
  end

endmodule

// File: tb/tb_bob_resolve_ctrl.sv
// Directed and randomized checks of bob_resolve_ctrl against a transaction-level model.
module tb_bob_resolve_ctrl;

  localparam int unsigned Flush = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        res_valid_i, res_ready_o, res_taken_i;
  logic [63:0] res_target_i;
  logic        ext_flush_i, bob_valid_i;
  logic [63:0] bob_pc_i;
  logic        bob_brdir_i, bob_ch_we_i, bob_ch_dir_i;
  logic [9:0]  bob_lochist_i;
  logic [11:0] bob_bhr_i;
  logic [3:0]  bob_rasptr_i;
  logic        bob_re_o, bob_flush_o, upd_valid_o, upd_taken_o, ch_we_o, ch_dir_o;
  logic [63:0] upd_pc_o, redirect_pc_o;
  logic [9:0]  upd_lochist_o, rest_lochist_o;
  logic [11:0] upd_bhr_o, rest_bhr_o;
  logic        redirect_valid_o, rest_valid_o;
  logic [3:0]  rest_rasptr_o;
  logic [31:0] br_cnt_o, mis_cnt_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mis = 0;

  bob_resolve_ctrl #(.FLUSH_CYCLES(Flush), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_taken_i(res_taken_i),
    .res_target_i(res_target_i), .ext_flush_i(ext_flush_i), .bob_valid_i(bob_valid_i),
    .bob_pc_i(bob_pc_i), .bob_brdir_i(bob_brdir_i), .bob_ch_we_i(bob_ch_we_i),
    .bob_ch_dir_i(bob_ch_dir_i), .bob_lochist_i(bob_lochist_i), .bob_bhr_i(bob_bhr_i),
    .bob_rasptr_i(bob_rasptr_i), .bob_re_o(bob_re_o), .bob_flush_o(bob_flush_o),
    .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
    .upd_lochist_o(upd_lochist_o), .upd_bhr_o(upd_bhr_o), .ch_we_o(ch_we_o),
    .ch_dir_o(ch_dir_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .rest_valid_o(rest_valid_o), .rest_bhr_o(rest_bhr_o), .rest_lochist_o(rest_lochist_o),
    .rest_rasptr_o(rest_rasptr_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_entry(input logic [63:0] pc, input logic [63:0] target,
                             input logic brdir, input logic taken, input logic chwe,
                             input logic chdir, input logic [9:0] lh, input logic [11:0] bhr,
                             input logic [3:0] ras);
    res_valid_i   = 1'b1;
    bob_valid_i   = 1'b1;
    res_taken_i   = taken;
    res_target_i  = target;
    bob_pc_i      = pc;
    bob_brdir_i   = brdir;
    bob_ch_we_i   = chwe;
    bob_ch_dir_i  = chdir;
    bob_lochist_i = lh;
    bob_bhr_i     = bhr;
    bob_rasptr_i  = ras;
    ext_flush_i   = 1'b0;
  endtask

  // One full resolution; the expected sequence is derived from the branch fields alone.
  task automatic do_branch(input logic [63:0] pc, input logic [63:0] target,
                           input logic brdir, input logic taken, input logic chwe,
                           input logic chdir, input logic [9:0] lh, input logic [11:0] bhr,
                           input logic [3:0] ras, input logic ext);
    logic        mis;
    logic        recover;
    logic [63:0] rpc;
    logic [11:0] rbhr;
    logic [9:0]  rlh;
    mis     = (brdir != taken);
    recover = mis && !ext;
    rpc     = taken ? target : pc + 64'd4;
    rbhr    = 12'((bhr * 2) + taken);
    rlh     = 10'((lh * 2) + taken);

    drive_entry(pc, target, brdir, taken, chwe, chdir, lh, bhr, ras);
    #1;
    chk("ready_idle", res_ready_o, 1);
    tick;
    res_valid_i = 1'b0;
    ext_flush_i = ext;
    #1;
    chk("cmp_bob_re", bob_re_o, 1);
    chk("cmp_upd_valid", upd_valid_o, 1);
    chk("cmp_upd_pc", upd_pc_o, pc);
    chk("cmp_upd_taken", upd_taken_o, taken);
    chk("cmp_upd_lochist", upd_lochist_o, lh);
    chk("cmp_upd_bhr", upd_bhr_o, bhr);
    chk("cmp_ch_we", ch_we_o, chwe);
    if (chwe) chk("cmp_ch_dir", ch_dir_o, chdir);
    chk("cmp_redirect", redirect_valid_o, 0);
    chk("cmp_flush", bob_flush_o, ext);
    chk("cmp_ready", res_ready_o, 0);
    tick;
    ext_flush_i = 1'b0;
    #1;
    if (recover) begin
      for (int i = 0; i < Flush; i++) begin
        chk("rec_flush", bob_flush_o, 1);
        chk("rec_ready", res_ready_o, 0);
        chk("rec_redirect_valid", redirect_valid_o, (i == 0));
        chk("rec_rest_valid", rest_valid_o, (i == 0));
        chk("rec_bob_re", bob_re_o, 0);
        if (i == 0) begin
          chk("rec_redirect_pc", redirect_pc_o, rpc);
          chk("rec_rest_bhr", rest_bhr_o, rbhr);
          chk("rec_rest_lochist", rest_lochist_o, rlh);
          chk("rec_rest_rasptr", rest_rasptr_o, ras);
        end
        tick;
      end
    end
    // Back in idle with the head still valid
    chk("post_redirect", redirect_valid_o, 0);
    chk("post_flush", bob_flush_o, 0);
    chk("post_bob_re", bob_re_o, 0);
    chk("post_ch_we", ch_we_o, 0);
    chk("post_ready", res_ready_o, 1);
    if (recover) chk("post_redirect_hold", redirect_pc_o, rpc);
    exp_br++;
    if (mis) exp_mis++;
    chk("br_cnt", br_cnt_o, exp_br);
    chk("mis_cnt", mis_cnt_o, exp_mis);
  endtask

  // Accepts a mispredicting branch and stops in the first recovery cycle.
  task automatic enter_recover(input logic [63:0] pc);
    drive_entry(pc, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 12'h0, 4'h0);
    tick;
    res_valid_i = 1'b0;
    tick;
    exp_br++;
    exp_mis++;
  endtask

  initial begin
    reset = 1'b1;
    res_valid_i = 0; res_taken_i = 0; res_target_i = '0; ext_flush_i = 0;
    bob_valid_i = 0; bob_pc_i = '0; bob_brdir_i = 0; bob_ch_we_i = 0; bob_ch_dir_i = 0;
    bob_lochist_i = '0; bob_bhr_i = '0; bob_rasptr_i = '0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_ready", res_ready_o, 0);
    chk("rst_flush", bob_flush_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_br_cnt", br_cnt_o, 0);
    chk("rst_mis_cnt", mis_cnt_o, 0);

    // Correct prediction
    do_branch(64'h100, 64'h1000, 1, 1, 0, 0, 10'h0, 12'h0, 4'h0, 0);
    // Mispredict not-taken
    do_branch(64'h2000, 64'h0, 1, 0, 0, 0, 10'h155, 12'h0F3, 4'h5, 0);
    // Mispredict taken with pc+4 unused, and wrap of pc+4
    do_branch(64'h3000, 64'hDEAD_BEE0, 0, 1, 0, 0, 10'h3FF, 12'hFFF, 4'hF, 0);
    do_branch(64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1, 0, 0, 0, 10'h200, 12'h800, 4'h1, 0);

    // Back-pressure: no BOB head for 3 cycles
    res_valid_i = 1'b1;
    bob_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", res_ready_o, 0);
      chk("bp_bob_re", bob_re_o, 0);
      tick;
    end
    do_branch(64'h4000, 64'h4400, 0, 0, 0, 0, 10'h1, 12'h2, 4'h3, 0);

    // Choice PHT updates
    do_branch(64'h5000, 64'h0, 0, 0, 1, 0, 10'h0, 12'h0, 4'h0, 0);
    do_branch(64'h5004, 64'h0, 1, 1, 1, 1, 10'h0, 12'h0, 4'h0, 0);

    // External flush during compare of a mispredict
    do_branch(64'h6000, 64'h0, 1, 0, 0, 0, 10'h0, 12'h0, 4'h0, 1);

    // External flush in idle blocks acceptance and drives flush
    ext_flush_i = 1'b1;
    #1;
    chk("ext_idle_ready", res_ready_o, 0);
    chk("ext_idle_flush", bob_flush_o, 1);
    tick;
    ext_flush_i = 1'b0;

    // External flush in the first recovery cycle cuts recovery short
    enter_recover(64'h7000);
    ext_flush_i = 1'b1;
    #1;
    chk("ext_rec_redirect", redirect_valid_o, 1);
    chk("ext_rec_flush", bob_flush_o, 1);
    tick;
    ext_flush_i = 1'b0;
    #1;
    chk("ext_rec_after_flush", bob_flush_o, 0);
    chk("ext_rec_after_ready", res_ready_o, 1);
    chk("ext_rec_mis_cnt", mis_cnt_o, exp_mis);

    // Randomized resolutions
    for (int n = 0; n < 40; n++) begin
      do_branch({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 10'($urandom), 12'($urandom), 4'($urandom),
                ($urandom_range(7) == 0));
    end

    // Reset in the first recovery cycle
    enter_recover(64'h8000);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bob_valid_i = 1'b0;
    exp_br = 0;
    exp_mis = 0;
    #1;
    chk("rr_redirect_valid", redirect_valid_o, 0);
    chk("rr_rest_valid", rest_valid_o, 0);
    chk("rr_flush", bob_flush_o, 0);
    chk("rr_bob_re", bob_re_o, 0);
    chk("rr_ready", res_ready_o, 0);
    chk("rr_redirect_pc", redirect_pc_o, 0);
    chk("rr_rest_bhr", rest_bhr_o, 0);
    chk("rr_upd_pc", upd_pc_o, 0);
    chk("rr_br_cnt", br_cnt_o, exp_br);
    chk("rr_mis_cnt", mis_cnt_o, exp_mis);
    tick;
    chk("rr_still_idle_flush", bob_flush_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
